pipe_ctrl: RTL and testbench

- Central pipeline sequencer for the five-stage core.
- Merges stall requests from ID and EX, and sequences multi-cycle EX operations (multiply-accumulate, divide) with a countdown.
- Arbitrates exception flushes from MEM.
- Drives the stall vector that freezes the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the flush/new-PC pair.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_ctrl.sv | 91 +++++++++
 tb/tb_pipe_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush sequencer with multi-cycle op countdown and stall perf counter
module pipe_ctrl #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              mc_start,
  input  logic [CNT_W-1:0]  mc_cycles,
  output logic              mc_done,
  input  logic              excp_req,
  input  logic [31:0]       excp_vec,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  input  logic              perf_clr,
  output logic [PERF_W-1:0] perf_stall,
  output logic [1:0]        fsm_state
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [5:0] STALL_EX = 6'b001111;
  localparam logic [5:0] STALL_ID = 6'b000111;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mc_done;
  logic [31:0]       r_new_pc;
  logic [PERF_W-1:0] r_perf;
  logic              w_mc_any;
  logic [5:0]        w_stall;

  assign w_mc_any = mc_start && (mc_cycles != '0);

  always_comb begin
    w_stall = !rst                        ? 6'b000000 :
              r_state == S_BUSY           ? STALL_EX  :
              r_state == S_FLUSH          ? 6'b000000 :
              (stallreq_ex || w_mc_any)   ? STALL_EX  :
              stallreq_id                 ? STALL_ID  : 6'b000000;
  end

  // Ops of 0 or 1 cycles never enter MC_BUSY; the start cycle itself covers the stall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_mc_done <= 1'b0;
      r_new_pc  <= '0;
      r_perf    <= '0;
    end else begin
      r_mc_done <= 1'b0;
      r_perf    <= perf_clr ? '0 : (w_stall[0] && !(&r_perf)) ? r_perf + 1'b1 : r_perf;
      case (r_state)
        S_IDLE: begin
          if (excp_req) begin
            r_state  <= S_FLUSH;
            r_new_pc <= excp_vec;
          end else if (mc_start) begin
            if (mc_cycles > CNT_W'(1)) begin
              r_state <= S_BUSY;
              r_cnt   <= mc_cycles - CNT_W'(1);
            end else r_mc_done <= 1'b1;
          end
        end
        S_BUSY: begin
          if (excp_req) begin
            r_state  <= S_FLUSH;
            r_new_pc <= excp_vec;
            r_cnt    <= '0;
          end else if (r_cnt == CNT_W'(1)) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_mc_done <= 1'b1;
          end else r_cnt <= r_cnt - CNT_W'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall      = w_stall;
  assign flush      = r_state == S_FLUSH;
  assign new_pc     = r_new_pc;
  assign mc_done    = r_mc_done;
  assign perf_stall = r_perf;
  assign fsm_state  = r_state;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench for pipe_ctrl; a narrow-counter twin checks saturation
module tb_pipe_ctrl;
  localparam logic [5:0] EX = 6'b001111;
  localparam logic [5:0] ID = 6'b000111;
  localparam logic [5:0] NO = 6'b000000;

  logic        clk = 1'b0;
  logic        rst, stallreq_id, stallreq_ex, mc_start, excp_req, perf_clr;
  logic [5:0]  mc_cycles;
  logic [31:0] excp_vec;
  logic        mc_done, flush, s_mc_done, s_flush;
  logic [5:0]  stall, s_stall;
  logic [31:0] new_pc, s_new_pc, perf_stall;
  logic [2:0]  s_perf;
  logic [1:0]  fsm_state, s_fsm_state;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(6), .PERF_W(32)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .mc_start(mc_start), .mc_cycles(mc_cycles), .mc_done(mc_done),
    .excp_req(excp_req), .excp_vec(excp_vec), .stall(stall), .flush(flush),
    .new_pc(new_pc), .perf_clr(perf_clr), .perf_stall(perf_stall), .fsm_state(fsm_state));

  pipe_ctrl #(.CNT_W(6), .PERF_W(3)) u_sat (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .mc_start(mc_start), .mc_cycles(mc_cycles), .mc_done(s_mc_done),
    .excp_req(excp_req), .excp_vec(excp_vec), .stall(s_stall), .flush(s_flush),
    .new_pc(s_new_pc), .perf_clr(perf_clr), .perf_stall(s_perf), .fsm_state(s_fsm_state));

  typedef struct {
    logic [5:0]  st;
    logic        fl;
    logic [31:0] pc;
    logic        dn;
    logic [1:0]  fs;
    logic [31:0] pf;
    logic [2:0]  ps;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] e_pc = 0, e_perf = 0;
  logic [2:0]  e_ps = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("stall", 32'(stall), 32'(e.st));
      chk("flush", 32'(flush), 32'(e.fl));
      chk("new_pc", new_pc, e.pc);
      chk("mc_done", 32'(mc_done), 32'(e.dn));
      chk("fsm_state", 32'(fsm_state), 32'(e.fs));
      chk("perf_stall", perf_stall, e.pf);
      chk("perf_sat", 32'(s_perf), 32'(e.ps));
    end
  end

  task automatic cyc(input logic rs, id, ex, ms, input logic [5:0] mcc, input logic xr,
                     input logic [31:0] xv, input logic clr,
                     input logic [5:0] est, input logic efl, edn, input logic [1:0] efs);
    @(posedge clk); #1;
    rst = rs; stallreq_id = id; stallreq_ex = ex; mc_start = ms; mc_cycles = mcc;
    excp_req = xr; excp_vec = xv; perf_clr = clr;
    q.push_back('{est, efl, e_pc, edn, efs, e_perf, e_ps});
    if (!rs || clr) begin
      e_perf = 0; e_ps = 0;
    end else if (est[0]) begin
      if (e_perf != 32'hFFFF_FFFF) e_perf++;
      if (e_ps != 3'd7) e_ps++;
    end
  endtask

  task automatic idle(input logic [5:0] est, input logic efl, edn, input logic [1:0] efs);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, est, efl, edn, efs);
  endtask

  initial begin
    rst = 0; stallreq_id = 0; stallreq_ex = 1; mc_start = 0; mc_cycles = 0;
    excp_req = 1; excp_vec = 32'h1234; perf_clr = 0;
    // reset held with competing requests
    repeat (3) cyc(0, 0, 1, 0, 0, 1, 32'h1234, 0, NO, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, EX, 0, 0, 0);
    // stall merge
    cyc(1, 1, 0, 0, 0, 0, 0, 0, ID, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0, EX, 0, 0, 0);
    idle(NO, 0, 0, 0);
    // 5-cycle op; stray mc_start and stallreq_id while busy are ignored
    cyc(1, 0, 0, 1, 5, 0, 0, 0, EX, 0, 0, 0);
    idle(EX, 0, 0, 1);
    cyc(1, 1, 0, 1, 2, 0, 0, 0, EX, 0, 0, 1);
    idle(EX, 0, 0, 1);
    idle(EX, 0, 0, 1);
    idle(NO, 0, 1, 0);
    idle(NO, 0, 0, 0);
    // 1-cycle and 0-cycle ops
    cyc(1, 0, 0, 1, 1, 0, 0, 0, EX, 0, 0, 0);
    idle(NO, 0, 1, 0);
    idle(NO, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0, 0, NO, 0, 0, 0);
    idle(NO, 0, 1, 0);
    idle(NO, 0, 0, 0);
    // 8-cycle op aborted by exception in third busy cycle; flush ignores all requests
    cyc(1, 0, 0, 1, 8, 0, 0, 0, EX, 0, 0, 0);
    idle(EX, 0, 0, 1);
    idle(EX, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1, 32'h20, 0, EX, 0, 0, 1);
    e_pc = 32'h20;
    cyc(1, 1, 1, 1, 3, 1, 32'h99, 0, NO, 1, 0, 2);
    repeat (8) idle(NO, 0, 0, 0);
    // exception and mc_start together
    cyc(1, 0, 0, 1, 4, 1, 32'h40, 0, EX, 0, 0, 0);
    e_pc = 32'h40;
    idle(NO, 1, 0, 2);
    idle(NO, 0, 0, 0);
    idle(NO, 0, 0, 0);
    // exception held high
    cyc(1, 0, 0, 0, 0, 1, 32'h80, 0, NO, 0, 0, 0);
    e_pc = 32'h80;
    cyc(1, 0, 0, 0, 0, 1, 32'h80, 0, NO, 1, 0, 2);
    cyc(1, 0, 0, 0, 0, 1, 32'h84, 0, NO, 0, 0, 0);
    e_pc = 32'h84;
    cyc(1, 0, 0, 0, 0, 1, 32'h84, 0, NO, 1, 0, 2);
    cyc(1, 0, 0, 0, 0, 1, 32'h88, 0, NO, 0, 0, 0);
    e_pc = 32'h88;
    idle(NO, 1, 0, 2);
    idle(NO, 0, 0, 0);
    // reset mid-operation abandons the op
    cyc(1, 0, 0, 1, 6, 0, 0, 0, EX, 0, 0, 0);
    idle(EX, 0, 0, 1);
    idle(EX, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, NO, 0, 0, 1);
    e_pc = 0;
    repeat (7) idle(NO, 0, 0, 0);
    // perf: clear alongside a stall, then saturate the narrow twin
    cyc(1, 0, 1, 0, 0, 0, 0, 0, EX, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 1, EX, 0, 0, 0);
    repeat (9) cyc(1, 0, 1, 0, 0, 0, 0, 0, EX, 0, 0, 0);
    idle(NO, 0, 0, 0);
    idle(NO, 0, 0, 0);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
